// File: rtl/spi_master_cfg_if.sv
// Bus bundle for spi_master_cfg: MCU-side handshake/config plus the SPI pins.
interface spi_master_cfg_if #(
   parameter int unsigned TX_W   = 12,
   parameter int unsigned RX_W   = 8,
   parameter int unsigned NUM_SS = 4,
   parameter int unsigned SEL_W  = 2,
   parameter int unsigned DIV_W  = 8
);
   logic              en;
   logic [SEL_W-1:0]  ss_sel;
   logic              cpol;
   logic              cpha;
   logic [DIV_W-1:0]  div;
   logic [TX_W-1:0]   send_data;
   logic              miso;
   logic              mosi;
   logic              sck;
   logic [NUM_SS-1:0] ss;
   logic [RX_W-1:0]   recv_data;
   logic              busy;
   logic              recv_data_rdy;

   modport master (
      input  en, ss_sel, cpol, cpha, div, send_data, miso,
      output mosi, sck, ss, recv_data, busy, recv_data_rdy
   );

   modport slave (
      output en, ss_sel, cpol, cpha, div, send_data, miso,
      input  mosi, sck, ss, recv_data, busy, recv_data_rdy
   );
endinterface

// File: rtl/spi_master_cfg.sv
// Parametrised SPI master: configurable frame widths, slave selects and SCK
// divider with runtime CPOL/CPHA; one frame per rising edge of en.
module spi_master_cfg #(
   parameter int unsigned TX_W   = 12,
   parameter int unsigned RX_W   = 8,
   parameter int unsigned NUM_SS = 4,
   parameter int unsigned SEL_W  = 2,
   parameter int unsigned DIV_W  = 8
) (
   input logic              clk,
   input logic              rst,
   spi_master_cfg_if.master bus
);
   localparam int unsigned N  = (TX_W > RX_W) ? TX_W : RX_W;
   localparam int unsigned EW = $clog2(2 * N + 1);

   typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;
   state_t state, state_nxt;

   logic             en_prev;
   logic             cpol_l, cpha_l;
   logic [DIV_W-1:0] div_l;
   logic [SEL_W-1:0] sel_l;
   logic [N-1:0]     tx_sr;
   logic [RX_W-1:0]  rx_sr;
   logic [DIV_W:0]   hp_cnt;
   logic [EW-1:0]    edge_cnt, edge_nxt;
   logic             sck_q, mosi_q, rdy_q;
   logic [RX_W-1:0]  recv_q;
   logic [N-1:0]     frame;
   logic             start, hp_done, toggle, do_sample, do_drive, done;

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      toggle    = 1'b0;
      done      = 1'b0;
      do_sample = 1'b0;
      do_drive  = 1'b0;
      frame     = N'(bus.send_data) << (N - TX_W);
      hp_done   = (hp_cnt == {1'b0, div_l});
      edge_nxt  = edge_cnt + EW'(1);
      case (state)
         IDLE:  if (bus.en && !en_prev) begin
                   start     = 1'b1;
                   state_nxt = LEAD;
                end
         LEAD:  if (hp_done) begin
                   toggle    = 1'b1;
                   state_nxt = XFER;
                end
         XFER:  if (hp_done) begin
                   if (edge_cnt == EW'(2 * N)) state_nxt = TRAIL;
                   else                        toggle    = 1'b1;
                end
         TRAIL: if (hp_done) begin
                   done      = 1'b1;
                   state_nxt = IDLE;
                end
         default: state_nxt = IDLE;
      endcase
      // Odd edges are leading; CPHA selects whether an edge samples or drives.
      if (toggle) begin
         if (edge_nxt[0] ^ cpha_l) do_sample = 1'b1;
         else                      do_drive  = (edge_nxt != EW'(2 * N));
      end
   end

   always_ff @(posedge clk) begin
      en_prev <= bus.en;
      if (!rst) begin
         cpol_l   <= 1'b0;
         cpha_l   <= 1'b0;
         div_l    <= '0;
         sel_l    <= '0;
         tx_sr    <= '0;
         rx_sr    <= '0;
         hp_cnt   <= '0;
         edge_cnt <= '0;
         sck_q    <= 1'b0;
         mosi_q   <= 1'b0;
         rdy_q    <= 1'b0;
         recv_q   <= '0;
      end else begin
         rdy_q <= 1'b0;
         if (start) begin
            cpol_l   <= bus.cpol;
            cpha_l   <= bus.cpha;
            div_l    <= bus.div;
            sel_l    <= bus.ss_sel;
            hp_cnt   <= '0;
            edge_cnt <= '0;
            rx_sr    <= '0;
            sck_q    <= bus.cpol;
            // CPHA=0 must present the first bit before the first (sampling) edge.
            mosi_q   <= bus.cpha ? 1'b0 : frame[N-1];
            tx_sr    <= bus.cpha ? frame : (frame << 1);
         end else if (state != IDLE) begin
            hp_cnt <= hp_done ? '0 : hp_cnt + (DIV_W + 1)'(1);
            if (toggle) begin
               sck_q    <= ~sck_q;
               edge_cnt <= edge_nxt;
            end
            if (do_sample) rx_sr <= (rx_sr << 1) | RX_W'(bus.miso);
            if (do_drive) begin
               mosi_q <= tx_sr[N-1];
               tx_sr  <= tx_sr << 1;
            end
            if (done) begin
               recv_q <= rx_sr;
               rdy_q  <= 1'b1;
               mosi_q <= 1'b0;
            end
         end
      end
   end

   always_comb begin
      bus.ss = '1;
      for (int unsigned i = 0; i < NUM_SS; i++)
         if (state != IDLE && 32'(sel_l) == i) bus.ss[i] = 1'b0;
   end

   assign bus.sck           = sck_q;
   assign bus.mosi          = mosi_q;
   assign bus.busy          = (state != IDLE);
   assign bus.recv_data     = recv_q;
   assign bus.recv_data_rdy = rdy_q;
endmodule

// File: tb/tb_spi_master_cfg.sv
// Directed + randomized bench for spi_master_cfg with a slot-level slave model.
module tb_spi_master_cfg;
   localparam int TX_W   = 12;
   localparam int RX_W   = 8;
   localparam int NUM_SS = 4;
   localparam int SEL_W  = 2;
   localparam int DIV_W  = 8;
   localparam int N      = (TX_W > RX_W) ? TX_W : RX_W;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   spi_master_cfg_if #(.TX_W(TX_W), .RX_W(RX_W), .NUM_SS(NUM_SS), .SEL_W(SEL_W), .DIV_W(DIV_W)) bus ();

   spi_master_cfg #(.TX_W(TX_W), .RX_W(RX_W), .NUM_SS(NUM_SS), .SEL_W(SEL_W), .DIV_W(DIV_W)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // Slave model: presents one slot bit per frame slot and records mosi at sample edges.
   logic         loopback = 1'b1;
   logic         slave_miso = 1'b0;
   logic         sl_cpha = 1'b0;
   logic [N-1:0] sl_slots = '0;
   logic [N-1:0] sl_seen = '0;
   int           sl_k = 0;
   logic         sl_psck = 1'b0, sl_pmosi = 1'b0, sl_pbusy = 1'b0;
   logic         sl_chg, sl_drv, sl_smp;

   assign bus.miso = loopback ? bus.mosi : slave_miso;

   always @(negedge clk) begin
      if (bus.busy && !sl_pbusy) begin
         sl_k       = 0;
         sl_seen    = '0;
         slave_miso = sl_slots[N-1];
      end else if (bus.busy) begin
         sl_chg = (bus.sck !== sl_psck);
         if (sl_chg) sl_k++;
         sl_drv = sl_chg && (sl_cpha ? (sl_k[0] == 1'b1) : (sl_k[0] == 1'b0 && sl_k < 2 * N));
         sl_smp = sl_chg && (sl_k[0] != sl_cpha);
         if (bus.mosi !== sl_pmosi) begin
            n_cmp++;
            assert (sl_drv) else begin
               n_bad++;
               $error("FAIL mosi_edge: mosi changed at sck edge %0d (sck_changed=%0b), required only on drive edges", sl_k, sl_chg);
            end
         end
         if (sl_drv) slave_miso = sl_slots[N-1-sl_k/2];
         if (sl_smp) sl_seen = {sl_seen[N-2:0], bus.mosi};
      end
      sl_psck  = bus.sck;
      sl_pmosi = bus.mosi;
      sl_pbusy = bus.busy;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [N-1:0] frame_of(input logic [TX_W-1:0] d);
      logic [N-1:0] f = '0;
      for (int s = 0; s < TX_W; s++) f[N-1-s] = d[TX_W-1-s];
      return f;
   endfunction

   function automatic logic [NUM_SS-1:0] ss_of(input int sel);
      logic [NUM_SS-1:0] r;
      for (int i = 0; i < NUM_SS; i++) r[i] = (i != sel);
      return r;
   endfunction

   task automatic start_frame(input logic cp, input logic ch, input logic [DIV_W-1:0] dv,
                              input logic [SEL_W-1:0] sel, input logic [TX_W-1:0] data,
                              input logic [N-1:0] slots, input logic lb);
      @(negedge clk);
      bus.cpol = cp; bus.cpha = ch; bus.div = dv; bus.ss_sel = sel;
      bus.send_data = data; bus.en = 1'b0;
      sl_cpha = ch; sl_slots = slots; loopback = lb;
      @(negedge clk);
      bus.en = 1'b1;
   endtask

   // mode 0: plain, 1: toggle en mid-frame, 2: reset at busy cycle 10, 3: chain next frame
   task automatic observe(input string tag, input int mode, input logic [NUM_SS-1:0] e_ss,
                          input int e_cyc, input logic [RX_W-1:0] e_recv, input logic [N-1:0] e_tx,
                          input logic e_sck, input logic [TX_W-1:0] nx_data, input logic nx_cpol);
      int w = 0, cyc = 0, ss_bad = 0, rdy_n = 0;
      while (bus.busy !== 1'b1 && w < 8) begin @(negedge clk); w++; end
      chk({tag, ".start"}, 32'(bus.busy), 32'(1));
      while (bus.busy === 1'b1 && cyc < 4000) begin
         cyc++;
         if (bus.ss !== e_ss) ss_bad++;
         if (bus.recv_data_rdy !== 1'b0) rdy_n++;
         if (mode == 1 && cyc == 20) bus.en = 1'b0;
         if (mode == 1 && cyc == 40) bus.en = 1'b1;
         if (mode == 3 && cyc == 5) begin
            bus.send_data = nx_data; bus.cpol = nx_cpol; bus.en = 1'b0;
         end
         if (mode == 2 && cyc == 10) begin
            rst = 1'b0;
            @(negedge clk);
            chk({tag, ".rst_ss"},   32'(bus.ss), 32'(4'hF));
            chk({tag, ".rst_busy"}, 32'(bus.busy), 32'(0));
            chk({tag, ".rst_sck"},  32'(bus.sck), 32'(0));
            chk({tag, ".rst_mosi"}, 32'(bus.mosi), 32'(0));
            chk({tag, ".rst_recv"}, 32'(bus.recv_data), 32'(0));
            chk({tag, ".rst_rdy"},  32'(bus.recv_data_rdy), 32'(0));
            rst = 1'b1;
            return;
         end
         @(negedge clk);
      end
      chk({tag, ".busy_cycles"}, 32'(cyc), 32'(e_cyc));
      chk({tag, ".ss_bad_cycles"}, 32'(ss_bad), 32'(0));
      chk({tag, ".rdy_during_busy"}, 32'(rdy_n), 32'(0));
      chk({tag, ".rdy"}, 32'(bus.recv_data_rdy), 32'(1));
      chk({tag, ".recv"}, 32'(bus.recv_data), 32'(e_recv));
      chk({tag, ".ss_idle"}, 32'(bus.ss), 32'(4'hF));
      chk({tag, ".sck_idle"}, 32'(bus.sck), 32'(e_sck));
      chk({tag, ".mosi_seq"}, 32'(sl_seen), 32'(e_tx));
      if (mode == 3) bus.en = 1'b1;
      @(negedge clk);
      chk({tag, ".rdy_one_cycle"}, 32'(bus.recv_data_rdy), 32'(0));
      if (mode == 3) chk({tag, ".chain_start"}, 32'(bus.busy), 32'(1));
   endtask

   initial begin
      int                quiet;
      logic              cp, ch, lb;
      logic [DIV_W-1:0]  dv;
      logic [SEL_W-1:0]  sel;
      logic [TX_W-1:0]   data;
      logic [N-1:0]      slots, fr;
      logic [RX_W-1:0]   er;

      bus.en = 1'b0; bus.cpol = 1'b0; bus.cpha = 1'b0; bus.div = '0;
      bus.ss_sel = '0; bus.send_data = '0;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset.ss",   32'(bus.ss), 32'(4'hF));
      chk("reset.sck",  32'(bus.sck), 32'(0));
      chk("reset.mosi", 32'(bus.mosi), 32'(0));
      chk("reset.busy", 32'(bus.busy), 32'(0));
      chk("reset.recv", 32'(bus.recv_data), 32'(0));
      chk("reset.rdy",  32'(bus.recv_data_rdy), 32'(0));
      rst = 1'b1;

      start_frame(1'b0, 1'b0, 8'd0, 2'd0, 12'hD5F, '0, 1'b1);
      observe("t1_mode0", 0, 4'b1110, 26, 8'h5F, 12'hD5F, 1'b0, '0, 1'b0);

      start_frame(1'b1, 1'b1, 8'd1, 2'd2, 12'h3C3, 12'h0A5, 1'b0);
      observe("t2_mode3", 0, 4'b1011, 52, 8'hA5, 12'h3C3, 1'b1, '0, 1'b0);

      start_frame(1'b0, 1'b1, 8'd2, 2'd3, 12'h55F, '0, 1'b1);
      observe("t3_mode1", 0, 4'b0111, 78, 8'h5F, 12'h55F, 1'b0, '0, 1'b0);
      start_frame(1'b1, 1'b0, 8'd2, 2'd1, 12'hAAF, '0, 1'b1);
      observe("t3_mode2", 0, 4'b1101, 78, 8'hAF, 12'hAAF, 1'b1, '0, 1'b0);

      start_frame(1'b0, 1'b0, 8'd1, 2'd0, 12'h123, 12'h0C3, 1'b0);
      observe("t4_en_toggle", 1, 4'b1110, 52, 8'hC3, 12'h123, 1'b0, '0, 1'b0);
      quiet = 0;
      repeat (10) begin @(negedge clk); if (bus.busy !== 1'b0) quiet++; end
      chk("t4.no_restart_en_high", 32'(quiet), 32'(0));

      start_frame(1'b1, 1'b0, 8'd0, 2'd0, 12'hF0F, '0, 1'b1);
      observe("t5_reset", 2, 4'b1110, 26, '0, '0, 1'b0, '0, 1'b0);
      quiet = 0;
      repeat (6) begin @(negedge clk); if (bus.recv_data_rdy !== 1'b0 || bus.busy !== 1'b0) quiet++; end
      chk("t5.quiet_after_reset", 32'(quiet), 32'(0));
      start_frame(1'b0, 1'b0, 8'd0, 2'd3, 12'h6B4, '0, 1'b1);
      observe("t5_clean", 0, 4'b0111, 26, 8'hB4, 12'h6B4, 1'b0, '0, 1'b0);

      start_frame(1'b0, 1'b0, 8'd0, 2'd1, 12'h3C7, '0, 1'b1);
      observe("t6_latched", 3, 4'b1101, 26, 8'hC7, 12'h3C7, 1'b0, 12'h9A1, 1'b1);
      observe("t6_chained", 0, 4'b1101, 26, 8'hA1, 12'h9A1, 1'b1, '0, 1'b0);

      for (int i = 0; i < 8; i++) begin
         cp    = 1'($urandom_range(0, 1));
         ch    = 1'($urandom_range(0, 1));
         lb    = 1'($urandom_range(0, 1));
         dv    = DIV_W'($urandom_range(0, 3));
         sel   = SEL_W'($urandom_range(0, NUM_SS - 1));
         data  = TX_W'($urandom);
         slots = N'($urandom);
         fr    = frame_of(data);
         er    = lb ? fr[RX_W-1:0] : slots[RX_W-1:0];
         start_frame(cp, ch, dv, sel, data, slots, lb);
         observe($sformatf("rnd%0d", i), 0, ss_of(int'(sel)), (2 * N + 2) * (int'(dv) + 1),
                 er, fr, cp, '0, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
